// File: rtl/sonic_pkg.sv
// rtl/sonic_pkg.sv - shared types and protocol constants for the sonic trigger/echo link
// Contents: responder state enum, default protocol constants shared with the
// controller, and a distance range helper.
package sonic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } sonic_state_e;

  // Protocol defaults; the controller uses the same values to time its side.
  localparam int unsigned DEF_MIN_TRIG_US = 10;
  localparam int unsigned DEF_US_PER_CM   = 58;
  localparam int unsigned DEF_TIMEOUT_US  = 38000;

  function automatic logic dist_in_range(input int unsigned d,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/sonic_cycle_timer.sv
// rtl/sonic_cycle_timer.sv - clearable saturating cycle counter with terminal compare
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force count to zero on the next edge (wins over en)
//   en        : advance the count by one, holding at all-ones
//   term      : terminal value to compare against
//   cnt       : current count
//   at_term   : cnt equals term
module sonic_cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term);

endmodule

// File: rtl/sonic_echo_responder.sv
// rtl/sonic_echo_responder.sv - HC-SR04-style responder: trigger qualify, burst delay, echo pulse
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   trig          : trigger from controller (already in clk domain)
//   dist_cm       : target distance, sampled when a trigger is accepted
//   echo          : echo pulse, width encodes distance
//   busy          : high during burst, echo and hold-off
//   trig_short    : one-cycle pulse when a trigger is rejected as too short
//   out_of_range  : last accepted distance was outside MIN_CM..MAX_CM
module sonic_echo_responder
  import sonic_pkg::*;
#(
  parameter int unsigned CLK_PER_US  = 100,
  parameter int unsigned MIN_TRIG_US = DEF_MIN_TRIG_US,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned US_PER_CM   = DEF_US_PER_CM,
  parameter int unsigned MIN_CM      = 2,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int unsigned HOLDOFF_US  = 10000,
  parameter int unsigned DIST_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] dist_cm,
  output logic              echo,
  output logic              busy,
  output logic              trig_short,
  output logic              out_of_range
);

  localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * CLK_PER_US;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1);

  // Terminal counts are "cycles - 1" because the counter is zero on the
  // first cycle of each state.
  localparam logic [CNT_W-1:0] TRIG_MIN_CNT = CNT_W'(MIN_TRIG_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] BURST_TERM   = CNT_W'(BURST_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_TERM = CNT_W'(HOLDOFF_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LEN  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ECHO_MULT    = CNT_W'(US_PER_CM * CLK_PER_US);

  // The in-range echo width must fit in the counter, which is sized by the timeout.
  if (MAX_CM * US_PER_CM > TIMEOUT_US) begin : g_range_check
    $error("sonic_echo_responder: MAX_CM*US_PER_CM exceeds TIMEOUT_US");
  end

  sonic_state_e     state_q, state_d;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic             trig_short_q, trig_short_d;
  logic             oor_q, oor_d;
  logic             trig_d_q, trig_d_d;
  logic [CNT_W-1:0] echo_len_q, echo_len_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_term;
  logic [CNT_W-1:0] cnt;
  logic             at_term;
  logic             accept;
  logic             reject;
  logic             in_range;

  sonic_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  assign in_range = dist_in_range(32'(dist_cm), MIN_CM, MAX_CM);

  // Trigger qualification happens on the first low sample after the high phase.
  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if ((state_q == TRIG_HI) && !trig) begin
      if (cnt >= TRIG_MIN_CNT) begin
        accept = 1'b1;
      end else begin
        reject = 1'b1;
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      echo_q       <= 1'b0;
      busy_q       <= 1'b0;
      trig_short_q <= 1'b0;
      oor_q        <= 1'b0;
      trig_d_q     <= 1'b1;
      echo_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      echo_q       <= echo_d;
      busy_q       <= busy_d;
      trig_short_q <= trig_short_d;
      oor_q        <= oor_d;
      trig_d_q     <= trig_d_d;
      echo_len_q   <= echo_len_d;
    end
  end

  // Next-state logic and timer control.
  always_comb begin
    state_d  = state_q;
    tmr_term = '1;
    unique case (state_q)
      IDLE: begin
        if (trig && !trig_d_q) begin
          state_d = TRIG_HI;
        end
      end
      TRIG_HI: begin
        if (accept) begin
          state_d = BURST;
        end else if (reject) begin
          state_d = IDLE;
        end
      end
      BURST: begin
        tmr_term = BURST_TERM;
        if (at_term) begin
          state_d = ECHO;
        end
      end
      ECHO: begin
        tmr_term = echo_len_q - CNT_W'(1);
        if (at_term) begin
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        tmr_term = HOLDOFF_TERM;
        if (at_term) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Count restarts on every state entry; in TRIG_HI it only counts high samples.
    tmr_clr = (state_d != state_q);
    tmr_en  = (state_q != TRIG_HI) || trig;
  end

  // Output logic: outputs are registered from the next state so they line up
  // with the state they describe.
  always_comb begin
    echo_d       = (state_d == ECHO);
    busy_d       = (state_d == BURST) || (state_d == ECHO) || (state_d == HOLDOFF);
    trig_short_d = reject;
    trig_d_d     = trig;
    oor_d        = oor_q;
    echo_len_d   = echo_len_q;
    if (accept) begin
      oor_d      = !in_range;
      echo_len_d = in_range ? (CNT_W'(dist_cm) * ECHO_MULT) : TIMEOUT_LEN;
    end
  end

  assign echo         = echo_q;
  assign busy         = busy_q;
  assign trig_short   = trig_short_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_sonic_echo_responder.sv
// tb/tb_sonic_echo_responder.sv - self-checking bench for sonic_echo_responder
module tb_sonic_echo_responder;

  localparam int CLK_PER_US  = 2;
  localparam int MIN_TRIG_US = 10;
  localparam int BURST_US    = 200;
  localparam int US_PER_CM   = 58;
  localparam int MIN_CM      = 2;
  localparam int MAX_CM      = 50;
  localparam int TIMEOUT_US  = 3000;
  localparam int HOLDOFF_US  = 50;

  localparam int MIN_TRIG_CYC = MIN_TRIG_US * CLK_PER_US;
  localparam int BURST_CYC    = BURST_US * CLK_PER_US;
  localparam int HOLDOFF_CYC  = HOLDOFF_US * CLK_PER_US;
  localparam int TIMEOUT_CYC  = TIMEOUT_US * CLK_PER_US;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b1;
  logic [8:0] dist_cm = '0;
  logic       echo, busy, trig_short, out_of_range;

  int checks = 0;
  int errors = 0;

  sonic_echo_responder #(
    .CLK_PER_US  (CLK_PER_US),
    .MIN_TRIG_US (MIN_TRIG_US),
    .BURST_US    (BURST_US),
    .US_PER_CM   (US_PER_CM),
    .MIN_CM      (MIN_CM),
    .MAX_CM      (MAX_CM),
    .TIMEOUT_US  (TIMEOUT_US),
    .HOLDOFF_US  (HOLDOFF_US),
    .DIST_W      (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trig         (trig),
    .dist_cm      (dist_cm),
    .echo         (echo),
    .busy         (busy),
    .trig_short   (trig_short),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  // Model: time-window view of the protocol. Edge n is the nth rising edge;
  // expected outputs are the values right after that edge.
  int   n        = 0;
  int   hi_len   = 0;
  logic prev     = 1'b1;
  int   acc_e    = 0;
  int   echo_s   = 0;
  int   echo_e   = 0;
  int   busy_e   = 0;
  int   short_at = -1;
  logic m_oor    = 1'b0;
  logic m_echo, m_busy, m_short;
  logic m_valid  = 1'b0;

  function automatic int echo_width(input int d);
    if (d >= MIN_CM && d <= MAX_CM) return d * US_PER_CM * CLK_PER_US;
    return TIMEOUT_CYC;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hi_len = 0; prev = 1'b1; m_oor = 1'b0; short_at = -1;
      acc_e = n; echo_s = n; echo_e = n; busy_e = n;
    end else begin
      if (n > busy_e) begin
        if (hi_len > 0) begin
          if (trig) begin
            hi_len++;
          end else begin
            if (hi_len >= MIN_TRIG_CYC) begin
              acc_e  = n;
              echo_s = n + BURST_CYC;
              echo_e = echo_s + echo_width(int'(dist_cm));
              busy_e = echo_e + HOLDOFF_CYC;
              m_oor  = !(int'(dist_cm) >= MIN_CM && int'(dist_cm) <= MAX_CM);
            end else begin
              short_at = n;
            end
            hi_len = 0;
          end
        end else if (trig && !prev) begin
          hi_len = 1;
        end
      end
      prev = trig;
    end
    m_echo  = (n >= echo_s) && (n < echo_e);
    m_busy  = (n >= acc_e) && (n < busy_e);
    m_short = (n == short_at);
    m_valid = 1'b1;
    n++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (echo !== m_echo) begin
        errors++; $display("FAIL model_echo edge %0d: got %b want %b", n - 1, echo, m_echo);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++; $display("FAIL model_busy edge %0d: got %b want %b", n - 1, busy, m_busy);
      end
      checks++;
      if (trig_short !== m_short) begin
        errors++; $display("FAIL model_trig_short edge %0d: got %b want %b", n - 1, trig_short, m_short);
      end
      checks++;
      if (out_of_range !== m_oor) begin
        errors++; $display("FAIL model_oor edge %0d: got %b want %b", n - 1, out_of_range, m_oor);
      end
    end
  end

  // Echo pulse width monitor.
  int run = 0;
  int last_width = 0;
  int n_pulses = 0;
  always @(negedge clk) begin
    if (echo === 1'b1) begin
      run++;
    end else if (run > 0) begin
      last_width = run; n_pulses++; run = 0;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // sel 0 = echo, 1 = busy. Returns negedges waited until the level is seen.
  task automatic wait_out(input int sel, input logic lvl, input int budget,
                          input string nm, output int cyc);
    logic v;
    cyc = 0;
    v = sel ? busy : echo;
    while (v !== lvl && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v = sel ? busy : echo;
    end
    if (v !== lvl) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles, got %b want %b", nm, cyc, v, lvl);
    end
  endtask

  task automatic fire(input int hi, input int d);
    @(negedge clk);
    dist_cm = 9'(d);
    trig = 1'b1;
    repeat (hi) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic run_one(input int hi, input int d, input int exp_w,
                         input int exp_oor, input string nm);
    int c;
    fire(hi, d);
    wait_out(1, 1'b1, 5, {nm, "_busy_rise"}, c);
    chk({nm, "_oor"}, int'(out_of_range), exp_oor);
    wait_out(0, 1'b1, BURST_CYC + 10, {nm, "_echo_rise"}, c);
    wait_out(0, 1'b0, TIMEOUT_CYC + 10, {nm, "_echo_fall"}, c);
    #1;
    chk({nm, "_width"}, last_width, exp_w);
    wait_out(1, 1'b0, HOLDOFF_CYC + 10, {nm, "_busy_fall"}, c);
  endtask

  initial begin
    int c, c2, s_cnt, e_cnt, b_cnt, pulses0;

    // Reset with trig held high through and after reset: not an edge.
    repeat (5) @(negedge clk);
    rst = 1'b0;
    s_cnt = 0; e_cnt = 0; b_cnt = 0;
    repeat (500) begin
      @(negedge clk);
      s_cnt += int'(trig_short); e_cnt += int'(echo); b_cnt += int'(busy);
    end
    chk("reset_echo_hi_cycles", e_cnt, 0);
    chk("reset_busy_hi_cycles", b_cnt, 0);
    chk("reset_short_cycles", s_cnt, 0);
    chk("reset_oor", int'(out_of_range), 0);
    trig = 1'b0;
    repeat (10) @(negedge clk);

    // Minimum-width trigger, dist 10: burst 400, echo 1160, hold-off 100.
    fire(20, 10);
    wait_out(1, 1'b1, 5, "d10_busy_rise", c);
    chk("d10_busy_latency", c, 1);
    wait_out(0, 1'b1, 1000, "d10_echo_rise", c);
    chk("d10_burst_cycles", c, 400);
    wait_out(1, 1'b0, 8000, "d10_busy_fall", c2);
    chk("d10_echo_plus_holdoff", c2, 1260);
    #1;
    chk("d10_width", last_width, 1160);
    chk("d10_oor", int'(out_of_range), 0);

    // One cycle short of minimum: rejected.
    fire(19, 7);
    s_cnt = 0; e_cnt = 0; b_cnt = 0;
    repeat (600) begin
      @(negedge clk);
      s_cnt += int'(trig_short); e_cnt += int'(echo); b_cnt += int'(busy);
    end
    chk("short_pulse_cycles", s_cnt, 1);
    chk("short_echo_cycles", e_cnt, 0);
    chk("short_busy_cycles", b_cnt, 0);

    // Out of range above max and at zero, then a max in-range distance.
    run_one(20, 51, 6000, 1, "d51");
    run_one(20, 0, 6000, 1, "d0");
    run_one(20, 50, 5800, 0, "d50");

    // Triggers during ECHO and HOLDOFF are ignored; dist changes have no effect.
    fire(20, 5);
    wait_out(0, 1'b1, BURST_CYC + 10, "ign_echo_rise", c);
    repeat (100) @(negedge clk);
    fire(25, 40);
    wait_out(0, 1'b0, 1000, "ign_echo_fall", c);
    #1;
    chk("ign_width", last_width, 580);
    pulses0 = n_pulses;
    repeat (10) @(negedge clk);
    fire(20, 40);
    repeat (600) @(negedge clk);
    chk("ign_no_extra_echo", n_pulses - pulses0, 0);
    run_one(20, 3, 348, 0, "d3_after_ignore");

    // Reset mid-echo.
    fire(20, 51);
    wait_out(0, 1'b1, BURST_CYC + 10, "rst_echo_rise", c);
    repeat (100) @(negedge clk);
    chk("rst_pre_oor", int'(out_of_range), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oor", int'(out_of_range), 0);
    repeat (5) @(negedge clk);
    run_one(20, 2, 232, 0, "d2_after_reset");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
